// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the M-extension execute unit.
//   - Funct3 op encodings for MUL/DIV instructions
//   - FSM state encoding
//   - default operand width
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: restoring radix-2 divider datapath on unsigned magnitudes.
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   load_i     capture dividend/divisor, clear remainder and counter
//   step_i     perform one restoring iteration this cycle
//   abort_i    discard the operation in flight
//   dividend_i / divisor_i   unsigned operands (XLEN)
//   quot_o / rem_o           unsigned quotient / remainder (XLEN)
//   done_o     high while the final (XLEN-th) iteration is being performed
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            done_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] dvsr_q;
  logic [CW-1:0]   cnt_q;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Shift next dividend bit into the remainder, then try the subtract;
  // a clear sign bit on the XLEN+1-bit difference means it fits.
  assign shifted = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni || abort_i) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
      cnt_q  <= '0;
    end else if (step_i && (cnt_q != CW'(XLEN))) begin
      if (!diff[XLEN]) begin
        rem_q  <= diff;
        quot_q <= {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q  <= shifted;
        quot_q <= {quot_q[XLEN-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o = step_i && (cnt_q == CW'(XLEN - 1));
  assign quot_o = quot_q;
  assign rem_o  = rem_q[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M execute-stage multiply/divide unit.
//   clk        clock
//   reset      synchronous active-low reset
//   StartE     M-op present in Execute, held until DoneE
//   Funct3E    op select (MUL..REMU)
//   SrcAE/SrcBE  forwarded operands
//   StallReqE  StartE & ~DoneE, toward hazard unit
//   DoneE      one-cycle pulse, ResultE valid
//   ResultE    registered result, held until next Done
//   BusyE      FSM not idle
// Multiply: pipelined, DoneE MUL_STAGES cycles after accept.
// Divide: XLEN-step restoring divider plus a sign-fix cycle; divide-by-zero
// and signed overflow complete in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            StallReqE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE,
  output logic            BusyE
);

  state_e state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic sq_q, sr_q, selrem_q;

  logic accept, abort, is_div, special;
  logic a_neg, b_neg;
  logic [XLEN-1:0] special_res, abs_a, abs_b;
  logic [XLEN-1:0] mul_comb, mul_res;
  logic mul_last_vld;
  logic div_load, div_done;
  logic [XLEN-1:0] quot, rem, quot_fix, rem_fix;

  assign accept = (state_q == S_IDLE) && StartE;
  assign abort  = !StartE && (state_q == S_MUL || state_q == S_DIV || state_q == S_FIX);
  assign is_div = Funct3E[2];

  // ---------------- special-case divide detection ----------------
  logic b_zero, ovf;
  assign b_zero  = (SrcBE == '0);
  assign ovf     = !Funct3E[0] && (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
  assign special = is_div && (b_zero || ovf);
  always_comb begin
    special_res = '0;
    if (b_zero) special_res = Funct3E[1] ? SrcAE : '1;
    else        special_res = Funct3E[1] ? '0 : SrcAE;
  end

  // ---------------- multiply ----------------
  logic a_sx, b_sx;
  logic signed [XLEN:0]     a_ext, b_ext;
  logic signed [2*XLEN+1:0] prod;
  assign a_sx  = (Funct3E == F3_MULH) || (Funct3E == F3_MULHSU);
  assign b_sx  = (Funct3E == F3_MULH);
  assign a_ext = {a_sx & SrcAE[XLEN-1], SrcAE};
  assign b_ext = {b_sx & SrcBE[XLEN-1], SrcBE};
  assign prod  = a_ext * b_ext;
  assign mul_comb = (Funct3E == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Stage 0 of the pipe is loaded at accept; the last stage feeds ResultE
  // as the FSM enters DONE. Single-stage builds bypass the pipe entirely.
  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign mul_res      = mul_comb;
      assign mul_last_vld = 1'b0;
    end else begin : g_mul_pipe
      logic [XLEN-1:0]         pipe_q [MUL_STAGES-1];
      logic [MUL_STAGES-2:0]   vld_q;
      always_ff @(posedge clk) begin
        if (!reset || abort) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= accept && !is_div;
          for (int unsigned i = 1; i < MUL_STAGES - 1; i++) vld_q[i] <= vld_q[i-1];
        end
        if (accept) pipe_q[0] <= mul_comb;
        for (int unsigned i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
      assign mul_res      = pipe_q[MUL_STAGES-2];
      assign mul_last_vld = vld_q[MUL_STAGES-2];
    end
  endgenerate

  // ---------------- divide ----------------
  assign a_neg = !Funct3E[0] && SrcAE[XLEN-1];
  assign b_neg = !Funct3E[0] && SrcBE[XLEN-1];
  assign abs_a = a_neg ? -SrcAE : SrcAE;
  assign abs_b = b_neg ? -SrcBE : SrcBE;

  div_iter #(.XLEN(XLEN)) u_div (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (div_load),
    .step_i     (state_q == S_DIV),
    .abort_i    (abort),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .quot_o     (quot),
    .rem_o      (rem),
    .done_o     (div_done)
  );

  assign quot_fix = sq_q ? -quot : quot;
  assign rem_fix  = sr_q ? -rem  : rem;

  // ---------------- FSM ----------------
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    div_load = 1'b0;
    case (state_q)
      S_IDLE: if (StartE) begin
        if (is_div) begin
          if (special) begin
            state_d = S_DONE;
            res_d   = special_res;
          end else begin
            state_d  = S_DIV;
            div_load = 1'b1;
          end
        end else if (MUL_STAGES == 1) begin
          state_d = S_DONE;
          res_d   = mul_comb;
        end else begin
          state_d = S_MUL;
        end
      end
      S_MUL: if (!StartE) state_d = S_IDLE;
             else if (mul_last_vld) begin
               state_d = S_DONE;
               res_d   = mul_res;
             end
      S_DIV: if (!StartE) state_d = S_IDLE;
             else if (div_done) state_d = S_FIX;
      S_FIX: if (!StartE) state_d = S_IDLE;
             else begin
               state_d = S_DONE;
               res_d   = selrem_q ? rem_fix : quot_fix;
             end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      selrem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (accept) begin
        sq_q     <= a_neg ^ b_neg;
        sr_q     <= a_neg;
        selrem_q <= Funct3E[1];
      end
    end
  end

  assign DoneE     = (state_q == S_DONE);
  assign BusyE     = (state_q != S_IDLE);
  assign ResultE   = res_q;
  assign StallReqE = StartE & ~DoneE;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic [2:0]  Funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic        StallReqE, DoneE, BusyE;
  logic [31:0] ResultE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .StartE    (StartE),
    .Funct3E   (Funct3E),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .StallReqE (StallReqE),
    .DoneE     (DoneE),
    .ResultE   (ResultE),
    .BusyE     (BusyE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op from the current cycle (N) holding StartE until DoneE;
  // returns latency in cycles (-1 on timeout), result and global cycle of Done.
  // StartE is dropped after the Done edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output int dcyc);
    lat = -1; res = 'x; dcyc = -1;
    Funct3E = f; SrcAE = a; SrcBE = b; StartE = 1'b1;
    for (int c = 0; c <= 50; c++) begin
      #2;
      if (DoneE) begin
        lat = c; res = ResultE; dcyc = cyc;
        break;
      end
      tick();
    end
    tick();
    StartE = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; StartE = 1'b0; Funct3E = '0; SrcAE = '0; SrcBE = '0;
    tick(); tick();
    reset = 1'b1;
    #2;
    checks++;
    if (DoneE !== 1'b0 || BusyE !== 1'b0 || ResultE !== 32'h0 || StallReqE !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: Done=%b Busy=%b Result=%h Stall=%b, required 0 0 00000000 0",
               DoneE, BusyE, ResultE, StallReqE);
    end
    tick();
  endtask

  task automatic test_mul_timing();
    logic [2:0] stall;
    logic [2:0] done;
    Funct3E = 3'b000; SrcAE = 32'd7; SrcBE = 32'hFFFFFFFD; StartE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      stall[c] = StallReqE;
      done[c]  = DoneE;
      if (c == 2) begin
        checks++;
        if (ResultE !== 32'hFFFFFFEB) begin
          failures++;
          $display("FAIL mul_result: got %h, required FFFFFFEB", ResultE);
        end
      end
      tick();
    end
    StartE = 1'b0;
    checks++;
    if (stall !== 3'b011) begin
      failures++;
      $display("FAIL mul_stall: StallReqE at N..N+2 = %b (bit0=N), required 011", stall);
    end
    checks++;
    if (done !== 3'b100) begin
      failures++;
      $display("FAIL mul_done_latency: DoneE at N..N+2 = %b (bit0=N), required 100", done);
    end
  endtask

  task automatic test_mulh();
    int lat, dc;
    logic [31:0] r;
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, r, dc);
    checks++;
    if (r !== 32'hFFFFFFFE || lat != 2) begin
      failures++;
      $display("FAIL mulhu: got %h lat %0d, required FFFFFFFE lat 2", r, lat);
    end
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, r, dc);
    checks++;
    if (r !== 32'h00000000 || lat != 2) begin
      failures++;
      $display("FAIL mulh: got %h lat %0d, required 00000000 lat 2", r, lat);
    end
    run_op(3'b010, 32'hFFFFFFFF, 32'd2, lat, r, dc);
    checks++;
    if (r !== 32'hFFFFFFFF || lat != 2) begin
      failures++;
      $display("FAIL mulhsu: got %h lat %0d, required FFFFFFFF lat 2", r, lat);
    end
  endtask

  task automatic test_div();
    int lat, dc;
    logic [31:0] r;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, lat, r, dc);
    checks++;
    if (r !== 32'hFFFFFFFD || lat != 34) begin
      failures++;
      $display("FAIL div_signed: got %h lat %0d, required FFFFFFFD lat 34", r, lat);
    end
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, lat, r, dc);
    checks++;
    if (r !== 32'hFFFFFFFF || lat != 34) begin
      failures++;
      $display("FAIL rem_signed: got %h lat %0d, required FFFFFFFF lat 34", r, lat);
    end
    run_op(3'b101, 32'd100, 32'd7, lat, r, dc);
    checks++;
    if (r !== 32'd14 || lat != 34) begin
      failures++;
      $display("FAIL divu: got %h lat %0d, required 0000000e lat 34", r, lat);
    end
    run_op(3'b111, 32'd100, 32'd7, lat, r, dc);
    checks++;
    if (r !== 32'd2 || lat != 34) begin
      failures++;
      $display("FAIL remu: got %h lat %0d, required 00000002 lat 34", r, lat);
    end
  endtask

  task automatic test_div_special();
    int lat, dc;
    logic [31:0] r;
    run_op(3'b101, 32'd5, 32'd0, lat, r, dc);
    checks++;
    if (r !== 32'hFFFFFFFF || lat != 1) begin
      failures++;
      $display("FAIL divu_by_zero: got %h lat %0d, required FFFFFFFF lat 1", r, lat);
    end
    run_op(3'b111, 32'd5, 32'd0, lat, r, dc);
    checks++;
    if (r !== 32'd5 || lat != 1) begin
      failures++;
      $display("FAIL remu_by_zero: got %h lat %0d, required 00000005 lat 1", r, lat);
    end
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, lat, r, dc);
    checks++;
    if (r !== 32'h80000000 || lat != 1) begin
      failures++;
      $display("FAIL div_overflow: got %h lat %0d, required 80000000 lat 1", r, lat);
    end
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, lat, r, dc);
    checks++;
    if (r !== 32'h00000000 || lat != 1) begin
      failures++;
      $display("FAIL rem_overflow: got %h lat %0d, required 00000000 lat 1", r, lat);
    end
  endtask

  task automatic test_abort();
    int lat, dc;
    int seen_done;
    logic [31:0] r;
    seen_done = 0;
    Funct3E = 3'b100; SrcAE = 32'd1000; SrcBE = 32'd3; StartE = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (DoneE) seen_done++;
      tick();
    end
    StartE = 1'b0;                  // cycle N+10
    #2;
    if (DoneE) seen_done++;
    tick();                          // cycle N+11
    #2;
    checks++;
    if (BusyE !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: BusyE=%b at N+11, required 0", BusyE);
    end
    for (int c = 0; c < 40; c++) begin
      if (DoneE) seen_done++;
      tick();
      #2;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d DoneE cycles after abort, required 0", seen_done);
    end
    tick();
    run_op(3'b000, 32'd3, 32'd4, lat, r, dc);
    checks++;
    if (r !== 32'd12 || lat != 2) begin
      failures++;
      $display("FAIL mul_after_abort: got %h lat %0d, required 0000000c lat 2", r, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    Funct3E = 3'b101; SrcAE = 32'd1000; SrcBE = 32'd3; StartE = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    reset = 1'b0;                     // cycle N+5
    tick();
    reset = 1'b1; StartE = 1'b0;
    #2;
    checks++;
    if (BusyE !== 1'b0 || DoneE !== 1'b0 || ResultE !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_div: Busy=%b Done=%b Result=%h, required 0 0 00000000",
               BusyE, DoneE, ResultE);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, d1, d2;
    logic [31:0] r1, r2;
    run_op(3'b000, 32'd5, 32'd6, lat1, r1, d1);
    #2;
    checks++;
    if (BusyE !== 1'b0) begin
      failures++;
      $display("FAIL done_no_reaccept: BusyE=%b after DONE with StartE high, required 0", BusyE);
    end
    run_op(3'b000, 32'd9, 32'd9, lat2, r2, d2);
    checks++;
    if (r1 !== 32'd30 || r2 !== 32'd81) begin
      failures++;
      $display("FAIL b2b_results: got %h %h, required 0000001e 00000051", r1, r2);
    end
    checks++;
    if (d2 - d1 != 3 || lat1 < 0) begin
      failures++;
      $display("FAIL b2b_spacing: DoneE separation %0d cycles, required 3", d2 - d1);
    end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mulh();
    test_div();
    test_div_special();
    test_abort();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
